// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_pkg
//  Description : Shared types and constants for the PIC interrupt-acknowledge
//                sequencer: handshake state enum, line/level/vector widths and
//                a rotating-priority rank helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    localparam int NUM_IR     = 8;  // only 8 lines are supported
    localparam int LEVEL_W    = 3;
    localparam int VEC_BASE_W = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INT_PEND = 2'd1,
        ACK1     = 2'd2,
        ACK2     = 2'd3
    } ack_state_t;

    // Rank of a level under rotating priority: 0 is the highest priority
    // (the level just after lowest), 7 is the lowest (lowest itself).
    function automatic logic [LEVEL_W-1:0] prio_rank(
        input logic [LEVEL_W-1:0] level,
        input logic [LEVEL_W-1:0] lowest
    );
        return level - lowest - LEVEL_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_priority_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : pic_priority_resolver
//  Description : Combinational rotating-priority encoder. Finds the highest
//                priority set bit of i_vec, where the level after
//                i_lowest_prio is the highest and order wraps modulo 8.
//  Ports       : i_vec         - candidate bit vector
//                i_lowest_prio - level currently holding lowest priority
//                o_valid       - at least one bit of i_vec is set
//                o_level       - highest-priority set level (valid w/ o_valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0]  i_vec,
    input  logic [LEVEL_W-1:0] i_lowest_prio,
    output logic               o_valid,
    output logic [LEVEL_W-1:0] o_level
);

    // Scan from lowest to highest priority so the last hit (highest
    // priority) overrides earlier ones; no "found" flag needed.
    always_comb begin
        o_valid = |i_vec;
        o_level = i_lowest_prio;
        for (int k = NUM_IR; k >= 1; k--) begin
            if (i_vec[i_lowest_prio + LEVEL_W'(k)]) begin
                o_level = i_lowest_prio + LEVEL_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pic_ack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pic_ack_sequencer
//  Description : 8259A-style interrupt arbiter and INTA sequencer. Selects the
//                highest-priority unmasked request under fully-nested rules,
//                raises int_out, runs the two-pulse INTA handshake (set ISR,
//                clear IRR, drive vector) and services EOI commands.
//  Build macro : ROTATION_EN - when defined, a non-specific EOI that clears
//                level k makes k the lowest priority (automatic rotation).
//                When undefined, priority is fixed with IR0 highest.
//  Ports       : clk, reset_n   - clock, async active-low reset
//                irr, imr       - latched requests, mask (1 = masked)
//                vec_base       - vector bits T7..T3
//                inta_n         - synchronized CPU acknowledge
//                eoi, seoi      - non-specific / specific EOI pulses
//                seoi_level     - level cleared by seoi
//                int_out        - interrupt request to CPU
//                irr_clear      - one-hot pulse clearing serviced IRR bit
//                isr            - in-service register
//                vector_out/oe  - interrupt vector and its bus enable
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_ack_sequencer
    import pic_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_IR-1:0]             irr,
    input  logic [NUM_IR-1:0]             imr,
    input  logic [VEC_BASE_W-1:0]         vec_base,
    input  logic                          inta_n,
    input  logic                          eoi,
    input  logic                          seoi,
    input  logic [LEVEL_W-1:0]            seoi_level,
    output logic                          int_out,
    output logic [NUM_IR-1:0]             irr_clear,
    output logic [NUM_IR-1:0]             isr,
    output logic [VEC_BASE_W+LEVEL_W-1:0] vector_out,
    output logic                          vector_oe
);

    localparam logic [LEVEL_W-1:0] c_RESET_LOWEST  = LEVEL_W'(NUM_IR - 1);
    localparam logic [LEVEL_W-1:0] c_SPURIOUS_LEVEL = LEVEL_W'(NUM_IR - 1);

    ack_state_t                    r_state;
    ack_state_t                    w_next_state;
    logic                          r_inta_d;
    logic [LEVEL_W-1:0]            r_level;
    logic [LEVEL_W-1:0]            w_level_next;
    logic [NUM_IR-1:0]             r_isr;
    logic [NUM_IR-1:0]             w_isr_next;
    logic [NUM_IR-1:0]             w_isr_after_eoi;
    logic                          r_int_out;
    logic                          w_int_out_next;
    logic [NUM_IR-1:0]             r_irr_clear;
    logic [NUM_IR-1:0]             w_irr_clear_next;
    logic [VEC_BASE_W+LEVEL_W-1:0] r_vector_out;
    logic [VEC_BASE_W+LEVEL_W-1:0] w_vector_out_next;
    logic                          r_vector_oe;
    logic                          w_vector_oe_next;
    logic                          w_set_en;

    logic [LEVEL_W-1:0]            w_lowest_prio;
    logic [NUM_IR-1:0]             w_req_bits;
    logic                          w_cand_valid;
    logic [LEVEL_W-1:0]            w_cand_level;
    logic                          w_isr_valid;
    logic [LEVEL_W-1:0]            w_isr_top;
    logic                          w_req_valid;
    logic                          w_inta_fall;
    logic                          w_inta_rise;
    logic                          w_eoi_ns;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req_bits = irr & ~imr;

    pic_priority_resolver u_req_resolver (
        .i_vec         (w_req_bits),
        .i_lowest_prio (w_lowest_prio),
        .o_valid       (w_cand_valid),
        .o_level       (w_cand_level)
    );

    pic_priority_resolver u_isr_resolver (
        .i_vec         (r_isr),
        .i_lowest_prio (w_lowest_prio),
        .o_valid       (w_isr_valid),
        .o_level       (w_isr_top)
    );

    // Fully nested: a request must strictly outrank everything in service.
    assign w_req_valid = w_cand_valid &&
                         (!w_isr_valid ||
                          (prio_rank(w_cand_level, w_lowest_prio) <
                           prio_rank(w_isr_top, w_lowest_prio)));

    assign w_inta_fall = r_inta_d & ~inta_n;
    assign w_inta_rise = ~r_inta_d & inta_n;

    // seoi takes precedence; a non-specific EOI with an empty isr is a no-op.
    assign w_eoi_ns = eoi & ~seoi & w_isr_valid;

`ifdef ROTATION_EN
    logic [LEVEL_W-1:0] r_lowest_prio;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lowest_prio <= c_RESET_LOWEST;
        end else if (w_eoi_ns) begin
            r_lowest_prio <= w_isr_top;
        end
    end

    assign w_lowest_prio = r_lowest_prio;
`else
    assign w_lowest_prio = c_RESET_LOWEST;
`endif

    // EOI is applied to the pre-set isr; the ISR set is OR-ed in afterwards
    // so that a same-bit collision leaves the bit set.
    always_comb begin
        w_isr_after_eoi = r_isr;
        if (seoi) begin
            w_isr_after_eoi[seoi_level] = 1'b0;
        end else if (w_eoi_ns) begin
            w_isr_after_eoi[w_isr_top] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake state machine: next state and next register values
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        w_set_en          = 1'b0;
        w_level_next      = r_level;
        w_vector_out_next = r_vector_out;

        case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    w_next_state = INT_PEND;
                end
            end
            INT_PEND: begin
                if (w_inta_fall) begin
                    w_next_state = ACK1;
                    if (w_req_valid) begin
                        w_set_en     = 1'b1;
                        w_level_next = w_cand_level;
                    end else begin
                        w_level_next = c_SPURIOUS_LEVEL;
                    end
                end else if (!w_req_valid) begin
                    w_next_state = IDLE;
                end
            end
            ACK1: begin
                if (w_inta_fall) begin
                    w_next_state      = ACK2;
                    w_vector_out_next = {vec_base, r_level};
                end
            end
            ACK2: begin
                if (w_inta_rise) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        w_irr_clear_next = w_set_en ? (NUM_IR'(1) << w_cand_level) : '0;
        w_isr_next       = w_isr_after_eoi | w_irr_clear_next;
        w_int_out_next   = (w_next_state == INT_PEND);
        w_vector_oe_next = (w_next_state == ACK2);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_inta_d     <= 1'b1;
            r_level      <= '0;
            r_isr        <= '0;
            r_int_out    <= 1'b0;
            r_irr_clear  <= '0;
            r_vector_out <= '0;
            r_vector_oe  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_inta_d     <= inta_n;
            r_level      <= w_level_next;
            r_isr        <= w_isr_next;
            r_int_out    <= w_int_out_next;
            r_irr_clear  <= w_irr_clear_next;
            r_vector_out <= w_vector_out_next;
            r_vector_oe  <= w_vector_oe_next;
        end
    end

    assign int_out    = r_int_out;
    assign irr_clear  = r_irr_clear;
    assign isr        = r_isr;
    assign vector_out = r_vector_out;
    assign vector_oe  = r_vector_oe;

endmodule
`default_nettype wire

// File: tb/tb_pic_ack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pic_ack_sequencer
//  Description : Self-checking bench for pic_ack_sequencer. Directed scenarios
//                followed by randomized requests/masks/EOIs, all checked
//                against a priority/ISR reference model kept in the bench.
//                Honours ROTATION_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_ack_sequencer;

`ifdef ROTATION_EN
    localparam bit c_ROT = 1'b1;
`else
    localparam bit c_ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       inta_n;
    logic       eoi;
    logic       seoi;
    logic [2:0] seoi_level;
    logic       int_out;
    logic [7:0] irr_clear;
    logic [7:0] isr;
    logic [7:0] vector_out;
    logic       vector_oe;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_isr;
    logic [7:0] m_vec;
    int         m_lowest;
    bit         m_int;

    pic_ack_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irr        (irr),
        .imr        (imr),
        .vec_base   (vec_base),
        .inta_n     (inta_n),
        .eoi        (eoi),
        .seoi       (seoi),
        .seoi_level (seoi_level),
        .int_out    (int_out),
        .irr_clear  (irr_clear),
        .isr        (isr),
        .vector_out (vector_out),
        .vector_oe  (vector_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rank(input int lvl, input int lowest);
        return (lvl - lowest - 1 + 16) % 8;
    endfunction

    // Highest-priority set level of bits, or -1 when empty.
    function automatic int top_level(input logic [7:0] bits, input int lowest);
        for (int r = 0; r < 8; r++) begin
            if (bits[(lowest + 1 + r) % 8]) return (lowest + 1 + r) % 8;
        end
        return -1;
    endfunction

    function automatic bit m_req_valid();
        int c;
        int t;
        c = top_level(irr & ~imr, m_lowest);
        t = top_level(m_isr, m_lowest);
        if (c < 0) return 1'b0;
        if (t < 0) return 1'b1;
        return rank(c, m_lowest) < rank(t, m_lowest);
    endfunction

    // mode: 0 none, 1 non-specific, 2 specific, 3 both (specific wins)
    task automatic m_eoi(input int mode, input int lvl);
        int t;
        if (mode >= 2) begin
            m_isr[lvl] = 1'b0;
        end else if (mode == 1) begin
            t = top_level(m_isr, m_lowest);
            if (t >= 0) begin
                m_isr[t] = 1'b0;
                if (c_ROT) m_lowest = t;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_eoi(input int mode, input int lvl);
        eoi        = (mode == 1) || (mode == 3);
        seoi       = (mode >= 2);
        seoi_level = 3'(lvl);
    endtask

    // One cycle outside a handshake: int_out follows req_valid of the
    // pre-edge inputs, EOI acts on the pre-edge isr.
    task automatic idle_step(input int mode, input int lvl, input string tag);
        drive_eoi(mode, lvl);
        m_int = m_req_valid();
        m_eoi(mode, lvl);
        step();
        eoi  = 1'b0;
        seoi = 1'b0;
        chk1({tag, ".int_out"}, int_out, m_int);
        chk8({tag, ".isr"}, isr, m_isr);
        chk8({tag, ".irr_clear"}, irr_clear, 8'h00);
    endtask

    // Full INTA handshake starting from a raised int_out.
    task automatic ack(input bit spurious, input int mode, input int lvl,
                       input bit rst_in_ack2, input string tag);
        bit         valid;
        int         lev;
        logic [7:0] onehot;
        if (spurious) irr = 8'h00;
        valid  = m_req_valid();
        lev    = valid ? top_level(irr & ~imr, m_lowest) : 7;
        onehot = valid ? (8'h01 << lev) : 8'h00;
        drive_eoi(mode, lvl);
        inta_n = 1'b0;
        m_eoi(mode, lvl);
        m_isr = m_isr | onehot;
        step();
        eoi  = 1'b0;
        seoi = 1'b0;
        chk1({tag, ".int_drop"}, int_out, 1'b0);
        chk8({tag, ".irr_clear"}, irr_clear, onehot);
        chk8({tag, ".isr_set"}, isr, m_isr);
        irr = irr & ~onehot;
        step();
        chk8({tag, ".irr_clear_end"}, irr_clear, 8'h00);
        inta_n = 1'b1;
        step();
        step();
        chk1({tag, ".oe_ack1"}, vector_oe, 1'b0);
        inta_n = 1'b0;
        step();
        m_vec = {vec_base, 3'(lev)};
        chk1({tag, ".oe_ack2"}, vector_oe, 1'b1);
        chk8({tag, ".vector"}, vector_out, m_vec);
        if (rst_in_ack2) begin
            #2 reset_n = 1'b0;
            #1;
            m_isr    = 8'h00;
            m_lowest = 7;
            m_vec    = 8'h00;
            chk1({tag, ".rst_oe"}, vector_oe, 1'b0);
            chk8({tag, ".rst_isr"}, isr, 8'h00);
            chk1({tag, ".rst_int"}, int_out, 1'b0);
            chk8({tag, ".rst_vec"}, vector_out, 8'h00);
            chk8({tag, ".rst_clr"}, irr_clear, 8'h00);
            inta_n = 1'b1;
            @(posedge clk);
            #1 reset_n = 1'b1;
        end else begin
            step();
            inta_n = 1'b1;
            step();
            chk1({tag, ".oe_end"}, vector_oe, 1'b0);
            chk8({tag, ".vector_hold"}, vector_out, m_vec);
            chk1({tag, ".int_end"}, int_out, 1'b0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int amode;
        int rmode;
        int lvl;

        reset_n    = 1'b0;
        irr        = 8'h00;
        imr        = 8'h00;
        vec_base   = 5'd0;
        inta_n     = 1'b1;
        eoi        = 1'b0;
        seoi       = 1'b0;
        seoi_level = 3'd0;
        m_isr      = 8'h00;
        m_vec      = 8'h00;
        m_lowest   = 7;
        m_int      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk1("reset.int_out", int_out, 1'b0);
        chk8("reset.irr_clear", irr_clear, 8'h00);
        chk8("reset.isr", isr, 8'h00);
        chk8("reset.vector_out", vector_out, 8'h00);
        chk1("reset.vector_oe", vector_oe, 1'b0);
        reset_n = 1'b1;
        idle_step(0, 0, "reset.idle");

        // Request with interrupt pending
        vec_base = 5'b01000;
        imr      = 8'h0A;
        irr      = 8'h0F;
        idle_step(0, 0, "t1.req");
        chk1("t1.int_raised", int_out, 1'b1);
        ack(1'b0, 0, 0, 1'b0, "t1.ack");
        chk8("t1.vector_40", vector_out, 8'h40);
        chk8("t1.isr_01", isr, 8'h01);
        idle_step(0, 0, "t1.blocked");
        irr = 8'h00;
        idle_step(1, 0, "t1.eoi");

        // Nesting block
        imr = 8'h00;
        irr = 8'h04;
        idle_step(0, 0, "t2.req2");
        ack(1'b0, 0, 0, 1'b0, "t2.ack2");
        irr = 8'h08;
        idle_step(0, 0, "t2.req3");
        idle_step(0, 0, "t2.req3b");
        chk1("t2.int_blocked", int_out, 1'b0);
        irr = 8'h02;
        idle_step(0, 0, "t2.req1");
        chk1("t2.int_nested", int_out, 1'b1);
        ack(1'b0, 0, 0, 1'b0, "t2.ack1");
        chk8("t2.isr_06", isr, 8'h06);

        // EOI
        irr = 8'h00;
        idle_step(1, 0, "t3.eoi");
        chk8("t3.isr_04", isr, 8'h04);
        idle_step(2, 2, "t3.seoi");
        chk8("t3.isr_00", isr, 8'h00);

        // Spurious request: irr drops in the cycle the first INTA fall is sampled
        irr = 8'h10;
        idle_step(0, 0, "t4.req");
        ack(1'b1, 0, 0, 1'b0, "t4.ack");
        chk8("t4.vector_spurious", vector_out, {vec_base, 3'd7});
        chk8("t4.isr_unchanged", isr, 8'h00);

        // Rotation
        irr = 8'h08;
        idle_step(0, 0, "t5.req3");
        ack(1'b0, 0, 0, 1'b0, "t5.ack3");
        idle_step(1, 0, "t5.eoi");
        irr = 8'h11;
        idle_step(0, 0, "t5.req11");
        ack(1'b0, 0, 0, 1'b0, "t5.ack11");
        chk8("t5.vector_low", {5'd0, vector_out[2:0]}, c_ROT ? 8'd4 : 8'd0);
        irr = 8'h00;
        idle_step(2, top_level(m_isr, m_lowest), "t5.clr");

        // EOI in the set cycle: same-bit seoi loses to the set
        irr = 8'h20;
        idle_step(0, 0, "t6.req5");
        ack(1'b0, 2, 5, 1'b0, "t6.ack_seoi_same");
        chk8("t6.set_wins", isr, 8'h20);
        // eoi+seoi together: seoi on an empty level, eoi must be dropped
        irr = 8'hFF;
        idle_step(0, 0, "t6.reqff");
        ack(1'b0, 3, 6, 1'b0, "t6.ack_both");
        irr = 8'h00;
        for (int l = 0; l < 8; l++) idle_step(2, l, "t6.clr");

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            imr   = 8'($urandom & $urandom);
            irr   = 8'($urandom);
            rmode = $urandom_range(0, 5);
            rmode = (rmode <= 2) ? 0 : rmode - 2;
            lvl   = $urandom_range(0, 7);
            idle_step(rmode, lvl, "rnd.step");
            if (m_int) begin
                amode = $urandom_range(0, 5);
                amode = (amode <= 2) ? 0 : amode - 2;
                ack($urandom_range(0, 7) == 0, amode, $urandom_range(0, 7), 1'b0, "rnd.ack");
            end
        end

        // Reset mid-handshake
        irr = 8'h00;
        imr = 8'h00;
        for (int l = 0; l < 8; l++) idle_step(2, l, "t7.clr");
        irr = 8'h01;
        idle_step(0, 0, "t7.req");
        ack(1'b0, 0, 0, 1'b1, "t7.ack");
        irr = 8'h01;
        idle_step(0, 0, "t7.rearb");
        chk1("t7.int_after_reset", int_out, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
